// File: rtl/uart_receiver.sv
// uart_receiver: 16x oversampled 8N1 receiver for inverted-data lines.
// Ports: sysclk, reset (async low), UART_RX, enable -> RX_DATA, RX_STATUS, frame_err, busy.
module uart_receiver #(
   parameter int CLK_FREQ = 100000000,
   parameter int BAUD     = 9600
) (
   input  logic       sysclk,
   input  logic       reset,
   input  logic       UART_RX,
   input  logic       enable,
   output logic [7:0] RX_DATA,
   output logic       RX_STATUS,
   output logic       frame_err,
   output logic       busy
);

   localparam int DIV = CLK_FREQ / (BAUD * 16);
   localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_IDLE
   } state_t;

   state_t state, state_n;

   logic          rx_s1, rx_s2, rx_d;
   logic          fall;
   logic [DW-1:0] div_cnt;
   logic          tick;
   logic [3:0]    cnt, cnt_n;
   logic [2:0]    idx, idx_n;
   logic [7:0]    sh, sh_n;
   logic          ld, fe;

   // Synchronizer plus one extra stage for falling-edge detection.
   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         rx_s1 <= 1'b1;
         rx_s2 <= 1'b1;
         rx_d  <= 1'b1;
      end else begin
         rx_s1 <= UART_RX;
         rx_s2 <= rx_s1;
         rx_d  <= rx_s2;
      end
   end

   assign fall = rx_d & ~rx_s2;

   // Free-running oversample divider; not realigned to the start edge.
   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         div_cnt <= '0;
      end else if (div_cnt == DIV_LAST) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   assign tick = (div_cnt == DIV_LAST);

   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      idx_n   = idx;
      sh_n    = sh;
      ld      = 1'b0;
      fe      = 1'b0;
      if (!enable) begin
         state_n = IDLE;
         cnt_n   = '0;
         idx_n   = '0;
         sh_n    = '0;
      end else begin
         unique case (state)
            IDLE: begin
               cnt_n = '0;
               idx_n = '0;
               if (fall) state_n = START;
            end
            START: begin
               if (tick) begin
                  if (cnt == 4'd7) begin
                     cnt_n   = '0;
                     idx_n   = '0;
                     state_n = rx_s2 ? IDLE : DATA;
                  end else begin
                     cnt_n = cnt + 4'd1;
                  end
               end
            end
            DATA: begin
               if (tick) begin
                  if (cnt == 4'd15) begin
                     cnt_n = '0;
                     // Line carries inverted data bits.
                     sh_n  = {~rx_s2, sh[7:1]};
                     idx_n = idx + 3'd1;
                     if (idx == 3'd7) state_n = STOP;
                  end else begin
                     cnt_n = cnt + 4'd1;
                  end
               end
            end
            STOP: begin
               if (tick) begin
                  if (cnt == 4'd15) begin
                     cnt_n = '0;
                     if (rx_s2) begin
                        ld      = 1'b1;
                        state_n = IDLE;
                     end else begin
                        fe      = 1'b1;
                        state_n = WAIT_IDLE;
                     end
                  end else begin
                     cnt_n = cnt + 4'd1;
                  end
               end
            end
            WAIT_IDLE: begin
               if (rx_s2) state_n = IDLE;
            end
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         cnt       <= '0;
         idx       <= '0;
         sh        <= '0;
         RX_DATA   <= 8'h00;
         RX_STATUS <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         cnt       <= cnt_n;
         idx       <= idx_n;
         sh        <= sh_n;
         RX_STATUS <= ld;
         frame_err <= fe;
         if (ld) RX_DATA <= sh;
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: randomized frames against a queue-based byte model.
// Drives uart_receiver at DIV=10 (160 sysclk per bit).
module tb_uart_receiver;

   localparam int BT = 160;

   logic       sysclk = 1'b0;
   logic       reset  = 1'b0;
   logic       UART_RX = 1'b1;
   logic       enable = 1'b1;
   logic [7:0] RX_DATA;
   logic       RX_STATUS;
   logic       frame_err;
   logic       busy;

   uart_receiver #(
      .CLK_FREQ(1536000),
      .BAUD    (9600)
   ) dut (
      .sysclk   (sysclk),
      .reset    (reset),
      .UART_RX  (UART_RX),
      .enable   (enable),
      .RX_DATA  (RX_DATA),
      .RX_STATUS(RX_STATUS),
      .frame_err(frame_err),
      .busy     (busy)
   );

   always #5 sysclk = ~sysclk;

   int checks = 0;
   int failures = 0;

   logic [7:0] got[$];
   logic [7:0] exp_q[$];
   int         n_fe = 0;
   int         exp_fe = 0;
   int         overlap = 0;
   int         wide = 0;
   int         ck = 0;
   logic [7:0] last_good = 8'h00;
   logic       prev_st = 1'b0;
   logic       prev_fe = 1'b0;

   task automatic chk(input string tag, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   always @(negedge sysclk) begin
      if (RX_STATUS) got.push_back(RX_DATA);
      if (frame_err) n_fe++;
      if (RX_STATUS && frame_err) overlap++;
      if ((RX_STATUS && prev_st) || (frame_err && prev_fe)) wide++;
      prev_st <= RX_STATUS;
      prev_fe <= frame_err;
   end

   task automatic clks(input int n);
      repeat (n) @(negedge sysclk);
   endtask

   task automatic line(input logic v, input int n);
      UART_RX = v;
      clks(n);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_ok);
      line(1'b0, BT);
      for (int i = 0; i < 8; i++) line(~b[i], BT);
      line(stop_ok, BT);
      UART_RX = 1'b1;
   endtask

   // Model: a frame counts as good iff it was not disturbed and its stop is 1.
   task automatic expect_frame(input logic [7:0] b, input logic stop_ok);
      if (stop_ok) begin
         exp_q.push_back(b);
         last_good = b;
      end else begin
         exp_fe++;
      end
   endtask

   task automatic verify(input string tag);
      chk({tag, "_count"}, got.size(), exp_q.size());
      for (int i = ck; i < got.size() && i < exp_q.size(); i++)
         chk({tag, "_byte"}, got[i], exp_q[i]);
      ck = exp_q.size();
      chk({tag, "_ferr"}, n_fe, exp_fe);
      chk({tag, "_hold"}, RX_DATA, last_good);
   endtask

   initial begin
      logic [7:0] b;
      logic       s;
      int         gap;

      clks(3);
      chk("rst_data", RX_DATA, 8'h00);
      chk("rst_status", RX_STATUS, 1'b0);
      chk("rst_ferr", frame_err, 1'b0);
      chk("rst_busy", busy, 1'b0);
      reset = 1'b1;
      clks(50);
      chk("idle_busy", busy, 1'b0);

      // Single frame; status must land before the stop bit ends.
      send_frame(8'hA5, 1'b1);
      expect_frame(8'hA5, 1'b1);
      chk("a5_latency", got.size(), 1);
      clks(100);
      verify("a5");

      // Back-to-back with zero gap.
      send_frame(8'h00, 1'b1);
      expect_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      expect_frame(8'hFF, 1'b1);
      clks(100);
      verify("b2b");

      // Bad stop bit, then line returns high.
      send_frame(8'h3C, 1'b0);
      expect_frame(8'h3C, 1'b0);
      clks(300);
      verify("stop0");

      // Short low glitch on idle line.
      line(1'b0, 40);
      line(1'b1, 80);
      chk("glitch_busy", busy, 1'b0);
      clks(200);
      verify("glitch");

      // Reset at data bit 4; remaining line bits of 8'h0F are high.
      fork
         send_frame(8'h0F, 1'b1);
         begin
            clks(5 * BT + 80);
            chk("pre_rst_busy", busy, 1'b1);
            reset = 1'b0;
            clks(2);
            chk("mrst_data", RX_DATA, 8'h00);
            chk("mrst_status", RX_STATUS, 1'b0);
            chk("mrst_ferr", frame_err, 1'b0);
            chk("mrst_busy", busy, 1'b0);
            clks(98);
            reset = 1'b1;
            clks(1);
            chk("post_rst_busy", busy, 1'b0);
         end
      join
      last_good = 8'h00;
      clks(100);
      send_frame(8'h5A, 1'b1);
      expect_frame(8'h5A, 1'b1);
      clks(100);
      verify("rst");

      // Enable dropped at data bit 2.
      fork
         send_frame(8'hC3, 1'b1);
         begin
            clks(3 * BT + 80);
            chk("pre_en_busy", busy, 1'b1);
            enable = 1'b0;
            clks(1);
            chk("en_busy", busy, 1'b0);
         end
      join
      clks(100);
      enable = 1'b1;
      clks(20);
      send_frame(8'h81, 1'b1);
      expect_frame(8'h81, 1'b1);
      clks(100);
      verify("en");

      // Random frames, roughly one in four with a bad stop bit.
      for (int k = 0; k < 10; k++) begin
         b = 8'($urandom);
         s = ($urandom_range(3) != 0);
         gap = s ? $urandom_range(0, 100) : $urandom_range(20, 100);
         send_frame(b, s);
         expect_frame(b, s);
         clks(gap);
      end
      clks(300);
      verify("rand");

      chk("no_overlap", overlap, 0);
      chk("one_cycle", wide, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100000000, meaning the sysclk frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, meaning the line bit rate in bit/s.
REQ-003 SHALL have port sysclk, input, 1 bit, the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port UART_RX, input, 1 bit, asynchronous serial line, idle high.
REQ-006 SHALL have port enable, input, 1 bit; high means reception is allowed.
REQ-007 SHALL have port RX_DATA, output, 8 bits, the last correctly framed byte.
REQ-008 SHALL have port RX_STATUS, output, 1 bit, a one-sysclk pulse when RX_DATA is updated.
REQ-009 SHALL have port frame_err, output, 1 bit, a one-sysclk pulse when a frame's stop bit samples low.
REQ-010 SHALL have port busy, output, 1 bit, high in every state except IDLE.

Function
REQ-011 SHALL pass UART_RX through a 2-flop synchronizer (reset value 1); all logic uses the synchronized value.
REQ-012 SHALL generate an internal 16x oversample tick, one sysclk wide, every DIV = CLK_FREQ/(BAUD*16) sysclk cycles (integer division), using a free-running divider counter.
REQ-013 SHALL treat the line format as 1 start bit (0), 8 data bits LSB first and transmitted inverted, then 1 stop bit (1); each received data bit SHALL be inverted before storage so RX_DATA equals the sender's byte.
REQ-014 SHALL implement the states IDLE, START, DATA, STOP and WAIT_IDLE.
REQ-015 IDLE: on a synchronized falling edge with enable=1 -> START, and the tick counter is cleared.
REQ-016 START: after 8 ticks (mid start bit), a sampled 0 -> DATA with the bit index at 0; a sampled 1 -> IDLE (glitch reject, no outputs).
REQ-017 DATA: sample one bit every 16 ticks, shifting into an 8-bit shift register LSB-first; after the 8th sample -> STOP.
REQ-018 STOP: sample 16 ticks after the last data bit; if 1 -> load RX_DATA, pulse RX_STATUS and go to IDLE; if 0 -> pulse frame_err, leave RX_DATA unchanged and go to WAIT_IDLE.
REQ-019 WAIT_IDLE: remain until the synchronized line is 1, then -> IDLE; a break or a stuck-low line SHALL produce exactly one frame_err.
REQ-020 Back-to-back frames SHALL be received without loss: a start edge arriving after the mid-stop sample SHALL be detected.
REQ-021 RX_STATUS and frame_err SHALL never be high in the same cycle; each pulse SHALL last exactly one sysclk.
REQ-022 enable=0 in any state SHALL force IDLE on the next sysclk, discard any partial byte and emit no pulse; RX_DATA holds its value.
REQ-023 Latency: RX_STATUS SHALL rise within DIV+3 sysclk of the mid-stop tick instant.

Reset
REQ-024 While reset=0: state=IDLE, RX_DATA=8'h00, RX_STATUS=0, frame_err=0, busy=0, synchronizer flops=1, all counters=0.
REQ-025 Deassertion of reset mid-frame SHALL leave the block in IDLE, waiting for a fresh falling edge; the partial frame is lost.

Verification (CLK_FREQ=1536000, BAUD=9600 -> DIV=10, 160 sysclk per bit)
REQ-026 Sender-convention byte 8'hA5 (line data bits ~8'hA5, LSB first, valid stop) -> one RX_STATUS pulse, RX_DATA=8'hA5, frame_err=0.
REQ-027 Two frames 8'h00 then 8'hFF with zero idle gap -> two RX_STATUS pulses, with RX_DATA=8'h00 and then 8'hFF.
REQ-028 Frame 8'h3C with stop bit forced 0, then line high -> one frame_err pulse, no RX_STATUS, RX_DATA retains its prior value.
REQ-029 A 40-sysclk low glitch on an idle line -> no pulses; busy returns to 0 by the mid-start check.
REQ-030 reset pulled low at data bit 4 of a frame, then released -> all outputs at reset values; the following valid frame 8'h5A is received correctly.
REQ-031 enable dropped at data bit 2, then raised -> no pulses, busy=0 on the next sysclk; the following frame 8'h81 is received correctly.
